// File: rtl/serial_subtractor4.sv
// ============================================================================
// Module      : serial_subtractor4
// Description : Bit-serial 4-bit subtractor (a - b - bin), LSB first, with
//               registered difference, borrow, overflow and zero flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic       ready,
    output logic [3:0] diff,
    output logic       bout,
    output logic       ovf,
    output logic       zero,
    output logic       done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       br_q, br_d;
    logic [3:0] a_sr_q, a_sr_d;
    logic [3:0] b_sr_q, b_sr_d;
    logic [3:0] dsr_q, dsr_d;
    logic [3:0] diff_q, diff_d;
    logic       bout_q, bout_d;
    logic       ovf_q, ovf_d;
    logic       zero_q, zero_d;

    logic       w_ai;
    logic       w_bi;
    logic       w_di;
    logic       w_br_next;
    logic [3:0] w_diff_full;

    // Operands shift right, so bit 0 always holds the bit under process;
    // on the last RUN edge it is the captured sign bit used for overflow.
    assign w_ai        = a_sr_q[0];
    assign w_bi        = b_sr_q[0];
    assign w_di        = w_ai ^ w_bi ^ br_q;
    assign w_br_next   = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & br_q);
    assign w_diff_full = {w_di, dsr_q[2:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        dsr_d   = dsr_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    cnt_d   = 2'd0;
                    dsr_d   = 4'd0;
                end
            end
            c_RUN: begin
                a_sr_d       = {1'b0, a_sr_q[3:1]};
                b_sr_d       = {1'b0, b_sr_q[3:1]};
                br_d         = w_br_next;
                dsr_d[cnt_q] = w_di;
                cnt_d        = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = c_DONE;
                    diff_d  = w_diff_full;
                    bout_d  = w_br_next;
                    ovf_d   = (w_ai ^ w_bi) & (w_di ^ w_ai);
                    zero_d  = (w_diff_full == 4'd0);
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            cnt_q   <= 2'd0;
            br_q    <= 1'b0;
            a_sr_q  <= 4'd0;
            b_sr_q  <= 4'd0;
            dsr_q   <= 4'd0;
            diff_q  <= 4'd0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            dsr_q   <= dsr_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign ready = (state_q == c_IDLE);
    assign done  = (state_q == c_DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor4.sv
// ============================================================================
// Module      : tb_serial_subtractor4
// Description : Scoreboard bench for serial_subtractor4 against an integer
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       ready;
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
    logic       zero;
    logic       done;

    typedef struct {
        logic [3:0] d;
        logic       bo;
        logic       ov;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    logic [3:0] prev_diff = 4'd0;
    logic       prev_bout = 1'b0;
    logic       prev_ovf  = 1'b0;
    logic       prev_zero = 1'b0;
    logic       prev_done = 1'b0;

    serial_subtractor4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin);
        exp_t e;
        int   r;
        int   sa;
        int   sbv;
        int   sr;
        r    = int'(ta) - int'(tb_v) - int'(tbin);
        sa   = (ta  > 4'd7) ? int'(ta)   - 16 : int'(ta);
        sbv  = (tb_v > 4'd7) ? int'(tb_v) - 16 : int'(tb_v);
        sr   = sa - sbv - int'(tbin);
        e.d  = 4'(r & 15);
        e.bo = (r < 0);
        e.ov = (sr < -8) || (sr > 7);
        e.z  = ((r & 15) == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_diff = 4'd0;
            prev_bout = 1'b0;
            prev_ovf  = 1'b0;
            prev_zero = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: got 2 consecutive done cycles, expected 1");
                end
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: got done with empty scoreboard, expected none");
                end else begin
                    e = sb.pop_front();
                    chk("diff", int'(diff), int'(e.d));
                    chk("bout", int'(bout), int'(e.bo));
                    chk("ovf",  int'(ovf),  int'(e.ov));
                    chk("zero", int'(zero), int'(e.z));
                end
            end else if ({diff, bout, ovf, zero} != {prev_diff, prev_bout, prev_ovf, prev_zero}) begin
                errors++;
                $display("FAIL hold: got outputs %h, expected held %h",
                         {diff, bout, ovf, zero}, {prev_diff, prev_bout, prev_ovf, prev_zero});
            end
            prev_diff = diff;
            prev_bout = bout;
            prev_ovf  = ovf;
            prev_zero = zero;
            prev_done = done;
        end
    end

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!ready) chk("ready_timeout", int'(ready), 1);
    endtask

    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                         input bit timing);
        wait_ready();
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        sb.push_back(model(ta, tb_v, tbin));
        @(negedge clk);
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        bin   = 1'($urandom);
        if (timing) begin
            for (int i = 1; i <= 6; i++) begin
                if (i > 1) @(negedge clk);
                if (i <= 5) chk("ready_busy", int'(ready), 0);
                if (i == 4) chk("done_early", int'(done), 0);
                if (i == 5) chk("done_latency", int'(done), 1);
                if (i == 6) chk("ready_back", int'(ready), 1);
            end
        end
    endtask

    initial begin
        int last_acc;
        int n_acc;
        int cyc;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        bin   = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_diff",  int'(diff),  0);
        chk("rst_bout",  int'(bout),  0);
        chk("rst_ovf",   int'(ovf),   0);
        chk("rst_zero",  int'(zero),  0);
        chk("rst_done",  int'(done),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(4'd9, 4'd3,  1'b0, 1'b1);
        do_op(4'd3, 4'd5,  1'b0, 1'b0);
        do_op(4'd8, 4'd1,  1'b0, 1'b0);
        do_op(4'd5, 4'd4,  1'b1, 1'b0);
        do_op(4'd0, 4'd15, 1'b1, 1'b0);
        do_op(4'd7, 4'd8,  1'b1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        end

        // Held start with operands scrambled while busy.
        wait_ready();
        last_acc = -1;
        n_acc    = 0;
        cyc      = 0;
        while (cyc < 100) begin
            if (ready) begin
                if (n_acc == 6) begin
                    start = 1'b0;
                    break;
                end
                start = 1'b1;
                a     = 4'($urandom);
                b     = 4'($urandom);
                bin   = 1'($urandom);
                sb.push_back(model(a, b, bin));
                if (last_acc >= 0) chk("spacing", cyc - last_acc, 6);
                last_acc = cyc;
                n_acc++;
            end else begin
                a   = 4'($urandom);
                b   = 4'($urandom);
                bin = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("held_ops", n_acc, 6);

        // Abort mid-run: async clear, no done pulse.
        wait_ready();
        a     = 4'd12;
        b     = 4'd7;
        bin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_diff",  int'(diff),  0);
        chk("abort_bout",  int'(bout),  0);
        chk("abort_ovf",   int'(ovf),   0);
        chk("abort_zero",  int'(zero),  0);
        chk("abort_done",  int'(done),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_op(4'd9, 4'd3, 1'b0, 1'b1);

        repeat (10) @(negedge clk);
        chk("pending", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
